pipe_ctrl: RTL and testbench

//  - Pipeline sequencer for the 5-stage core: drives stall[5:0] to PC/IF/ID/EX/MEM/WB registers and the

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pipe_ctrl_if.sv | 22 ++
 rtl/stall_watchdog.sv | 33 +++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: stall masks, exception codes and the pipe_ctrl FSM encoding.
package cpu_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-to-sequencer bundle: stall requests and exception info in, stall/flush/redirect out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles; raises a sticky flag once LIMIT is reached.
module stall_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall_active,
  output logic timeout_sticky
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      if (!stall_active)
        count_q <= '0;
      else if (count_q != LIM)
        count_q <= count_q + 1'b1;
      // Flag rises on the same edge the count reaches LIMIT.
      if (stall_active && count_q == LIM_M1)
        timeout_sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, drain->flush->redirect sequencing, hung-stall watchdog.
// Optional PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  pipe_ctrl_if.slave   bus,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt,
`endif
  output logic         stall_timeout
);

  pipe_state_e state_q, state_d;
  logic [31:0] new_pc_q;
  logic [5:0]  stall_mux;
  logic        exc_pending;
  logic        is_eret;

  assign exc_pending = (bus.excepttype != EXC_NONE);
  assign is_eret     = (bus.excepttype == EXC_ERET);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      new_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN && exc_pending)
        new_pc_q <= is_eret ? bus.cp0_epc : EXC_VECTOR;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    stall_mux = STALL_NONE;
    unique case (state_q)
      ST_RUN: begin
        if (exc_pending) begin
          stall_mux = STALL_ALL;
          state_d   = bus.stallreq_mem ? ST_DRAIN : ST_FLUSH;
        end else if (bus.stallreq_mem) stall_mux = STALL_MEM;
        else if (bus.stallreq_ex)      stall_mux = STALL_EX;
        else if (bus.stallreq_id)      stall_mux = STALL_ID;
        else if (bus.stallreq_if)      stall_mux = STALL_IF;
      end
      ST_DRAIN: begin
        stall_mux = STALL_ALL;
        if (!bus.stallreq_mem) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        stall_mux = STALL_NONE;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Stall is combinational, so hold it low while reset is asserted.
  assign bus.stall  = reset_n ? stall_mux : STALL_NONE;
  assign bus.flush  = (state_q == ST_FLUSH);
  assign bus.new_pc = new_pc_q;

  stall_watchdog #(.LIMIT(STALL_TIMEOUT)) u_watchdog (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_active   (bus.stall[0]),
    .timeout_sticky (stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.stall[0])         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (state_q == ST_FLUSH)  perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: priority, exception/ERET/drain sequencing, watchdog, reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic stall_timeout;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .STALL_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.excepttype   = 32'h0;
  endtask

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.cp0_epc = 32'h0;
    clear_inputs();
    #3;
    check("rst_stall",   32'(bus.stall), 32'h00);
    check("rst_flush",   32'(bus.flush), 32'h0);
    check("rst_new_pc",  bus.new_pc,     32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);
    next_cycle();
    reset_n = 1'b1;

    // Priority, all within one half-cycle so the watchdog never counts.
    next_cycle();
    bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1; #1;
    check("prio_id_ex", 32'(bus.stall), 32'h0f);
    bus.stallreq_mem = 1'b1; #1;
    check("prio_mem", 32'(bus.stall), 32'h1f);
    clear_inputs(); bus.stallreq_if = 1'b1; #1;
    check("prio_if", 32'(bus.stall), 32'h03);
    clear_inputs(); #1;
    check("prio_none", 32'(bus.stall), 32'h00);

    // Syscall, no MEM wait; FLUSH must ignore the still-present exception and EX request.
    next_cycle();
    bus.excepttype = 32'h8; #1;
    check("exc_stall_n", 32'(bus.stall), 32'h3f);
    check("exc_flush_n", 32'(bus.flush), 32'h0);
    next_cycle();
    bus.stallreq_ex = 1'b1; #1;
    check("exc_flush_n1", 32'(bus.flush), 32'h1);
    check("exc_pc_n1",    bus.new_pc,     32'h20);
    check("exc_stall_n1", 32'(bus.stall), 32'h00);
    clear_inputs();
    next_cycle(); #1;
    check("exc_flush_n2", 32'(bus.flush), 32'h0);

    // ERET redirects to EPC.
    bus.excepttype = 32'he; bus.cp0_epc = 32'h8000_1000;
    next_cycle();
    clear_inputs(); #1;
    check("eret_flush", 32'(bus.flush), 32'h1);
    check("eret_pc",    bus.new_pc,     32'h8000_1000);
    next_cycle(); #1;
    check("eret_done",  32'(bus.flush), 32'h0);
    check("eret_hold",  bus.new_pc,     32'h8000_1000);

    // Overflow while MEM waits: 4 frozen cycles, EPC change ignored, flush after mem drops.
    bus.excepttype = 32'hc; bus.stallreq_mem = 1'b1; #1;
    check("drain_stall0", 32'(bus.stall), 32'h3f);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      bus.excepttype = 32'h0; bus.cp0_epc = 32'h1234_5678; #1;
      check($sformatf("drain_stall%0d", i), 32'(bus.stall), 32'h3f);
      check($sformatf("drain_flush%0d", i), 32'(bus.flush), 32'h0);
    end
    next_cycle();
    bus.stallreq_mem = 1'b0; #1;
    check("drain_last_stall", 32'(bus.stall), 32'h3f);
    next_cycle(); #1;
    check("drain_flush", 32'(bus.flush), 32'h1);
    check("drain_pc",    bus.new_pc,     32'h20);
    next_cycle(); #1;
    check("drain_done",  32'(bus.flush), 32'h0);

    // Watchdog with limit 8.
    bus.stallreq_ex = 1'b1;
    repeat (7) next_cycle();
    #1 check("wd_7", 32'(stall_timeout), 32'h0);
    next_cycle(); #1;
    check("wd_8", 32'(stall_timeout), 32'h1);
    bus.stallreq_ex = 1'b0;
    repeat (2) next_cycle();
    #1 check("wd_sticky", 32'(stall_timeout), 32'h1);

    // Reset in the middle of DRAIN.
    next_cycle();
    bus.excepttype = 32'h8; bus.stallreq_mem = 1'b1;
    next_cycle();
    bus.excepttype = 32'h0; #1;
    check("rd_in_drain", 32'(bus.stall), 32'h3f);
    reset_n = 1'b0; #1;
    check("rd_stall",   32'(bus.stall), 32'h00);
    check("rd_flush",   32'(bus.flush), 32'h0);
    check("rd_new_pc",  bus.new_pc,     32'h0);
    check("rd_timeout", 32'(stall_timeout), 32'h0);
    next_cycle();
    bus.stallreq_mem = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      check($sformatf("rd_noflush%0d", i), 32'(bus.flush), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
